// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I main controller (Moore FSM driving datapath selects/enables).
// Optional `MC_CTRL_ILLEGAL_TRAP_EN traps unknown encodings in a sticky ILLEGAL state.
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       mem_ready,
  input  logic       Zero,
  input  logic       Sign,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] ALUOp,
  output logic       instr_done,
  output logic       illegal
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL
  } state_t;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam logic   TRAP_EN = 1'b1;
  localparam state_t TRAP    = ILLEGAL;
`else
  localparam logic   TRAP_EN = 1'b0;
  localparam state_t TRAP    = FETCH;
`endif
  state_t state, next;
  logic bad, taken, pcw, irw, memw, regw, done;
  logic [3:0] alu_op, br_op;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else        state <= next;
  assign bad = !(opcode inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111})
               || (opcode == 7'b1100011 && funct3[2:1] == 2'b01);
  always_comb begin
    case (funct3)
      3'b000:  alu_op = (state == EXECR && funct7b5) ? 4'd1 : 4'd0;
      3'b001:  alu_op = 4'd6;
      3'b010:  alu_op = 4'd5;
      3'b011:  alu_op = 4'd10;
      3'b100:  alu_op = 4'd4;
      3'b101:  alu_op = funct7b5 ? 4'd9 : 4'd8;
      3'b110:  alu_op = 4'd3;
      default: alu_op = 4'd2;
    endcase
  end
  // blt/bge use slt (result nonzero when less); bltu/bgeu use op 11 whose sign flags "less"
  assign br_op = funct3[2] ? (funct3[1] ? 4'd11 : 4'd5) : 4'd1;
  assign taken = funct3[1] ? (Sign ^ funct3[0]) : ((Zero ^ funct3[2]) ^ funct3[0]);
  always_comb begin
    next = state;
    case (state)
      FETCH:    next = mem_ready ? DECODE : FETCH;
      DECODE:
        if (bad) next = TRAP;
        else
          case (opcode)
            7'b0000011, 7'b0100011: next = MEMADR;
            7'b0110011: next = EXECR;
            7'b0010011: next = EXECI;
            7'b1100011: next = BRANCH;
            7'b1101111: next = JAL;
            7'b1100111: next = JALR;
            7'b0110111: next = LUI;
            default:    next = AUIPC;
          endcase
      MEMADR:   next = (opcode == 7'b0000011) ? MEMREAD : MEMWRITE;
      MEMREAD:  next = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: next = mem_ready ? FETCH : MEMWRITE;
      EXECR, EXECI, LUI, AUIPC, JAL: next = ALUWB;
      JALR:     next = JAL;
      MEMWB, ALUWB, BRANCH: next = FETCH;
      default:  next = ILLEGAL;
    endcase
  end
  always_comb begin
    pcw = 1'b0; irw = 1'b0; memw = 1'b0; regw = 1'b0; done = 1'b0;
    AdrSrc = 1'b0; ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b00; ALUOp = 4'd0;
    case (state)
      FETCH:    begin ALUSrcB = 2'b10; ResultSrc = 2'b10; pcw = mem_ready; irw = mem_ready; end
      DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; done = bad && !TRAP_EN; end
      MEMADR, JALR: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = 2'b01; regw = 1'b1; done = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; memw = 1'b1; done = mem_ready; end
      EXECR:    begin ALUSrcA = 2'b10; ALUOp = alu_op; end
      EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = alu_op; end
      ALUWB:    begin regw = 1'b1; done = 1'b1; end
      BRANCH:   begin ALUSrcA = 2'b10; ALUOp = br_op; pcw = taken; done = 1'b1; end
      JAL:      begin pcw = 1'b1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; end
      LUI:      begin ALUSrcA = 2'b11; ALUSrcB = 2'b01; end
      AUIPC:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      default:  ;
    endcase
  end
  // reset masks every enable combinationally so nothing glitches while rst_n is low
  assign PCWrite    = pcw & rst_n;
  assign IRWrite    = irw & rst_n;
  assign MemWrite   = memw & rst_n;
  assign RegWrite   = regw & rst_n;
  assign instr_done = done & rst_n;
  assign illegal    = TRAP_EN && state == ILLEGAL;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: random instruction stream checked cycle-by-cycle against a per-instruction
// step-list model, plus directed literal checks from the test plan.
module tb_mc_control_fsm;
  logic clk = 0, rst_n = 0, funct7b5 = 0, mem_ready = 0, Zero = 0, Sign = 0;
  logic [6:0] opcode = 0;
  logic [2:0] funct3 = 0;
  logic PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, instr_done, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] ALUOp;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic adr; logic [1:0] a, b, rs; logic [3:0] op;
    logic pcw, memw, regw, done, wt, rp, rd;
  } step_t;
  step_t q[$];
  logic force_q[$];
  bit all_rdy = 0;
  logic [3:0] op_at [16];
  logic [1:0] b_at [16], rs_at [16];
  logic pcw_at [16], regw_at [16], done_at [16];
  int regw_n, memw_n, adr_n, done_n;
  logic [6:0] opc_tab [10];
  always #5 clk = ~clk;
  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .mem_ready(mem_ready), .Zero(Zero), .Sign(Sign), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .instr_done(instr_done),
    .illegal(illegal)
  );
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask
  function automatic step_t mk(input logic adr, input logic [1:0] a, b, rs, input logic [3:0] op,
                               input logic pcw, memw, regw, done, wt, rp, rd);
    step_t s;
    s.adr = adr; s.a = a; s.b = b; s.rs = rs; s.op = op; s.pcw = pcw; s.memw = memw;
    s.regw = regw; s.done = done; s.wt = wt; s.rp = rp; s.rd = rd;
    return s;
  endfunction
  function automatic logic [3:0] alu_model(input bit r, input logic [2:0] f3, input logic f7);
    int t [8];
    int v;
    t = '{0, 6, 5, 10, 4, 8, 3, 2};
    v = t[f3];
    if (f3 == 0 && r && f7) v = 1;
    if (f3 == 5 && f7) v = 9;
    return 4'(v);
  endfunction
  function automatic bit legal(input logic [6:0] opc, input logic [2:0] f3);
    return (opc inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17})
           && !(opc == 7'h63 && (f3 == 2 || f3 == 3));
  endfunction
  task automatic build(input logic [6:0] opc, input logic [2:0] f3, input logic f7, z, s);
    step_t wb, jal, adr;
    logic tk;
    wb  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    jal = mk(0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    adr = mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tk = (f3 == 0) ? z : (f3 == 1 || f3 == 4) ? !z : (f3 == 5) ? z : (f3 == 6) ? s : !s;
    q.delete();
    q.push_back(mk(0, 0, 2, 2, 0, 0, 0, 0, 0, 1, 1, 0));
    q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, !legal(opc, f3), 0, 0, 0));
    if (legal(opc, f3))
      case (opc)
        7'h03: begin q.push_back(adr); q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
                     q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0)); end
        7'h23: begin q.push_back(adr); q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1)); end
        7'h33: begin q.push_back(mk(0, 2, 0, 0, alu_model(1, f3, f7), 0, 0, 0, 0, 0, 0, 0)); q.push_back(wb); end
        7'h13: begin q.push_back(mk(0, 2, 1, 0, alu_model(0, f3, f7), 0, 0, 0, 0, 0, 0, 0)); q.push_back(wb); end
        7'h63: q.push_back(mk(0, 2, 0, 0, f3 < 4 ? 4'd1 : f3 < 6 ? 4'd5 : 4'd11, tk, 0, 0, 1, 0, 0, 0));
        7'h67: begin q.push_back(adr); q.push_back(jal); q.push_back(wb); end
        7'h6f: begin q.push_back(jal); q.push_back(wb); end
        7'h37: begin q.push_back(mk(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); q.push_back(wb); end
        default: begin q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); q.push_back(wb); end
      endcase
  endtask
  task automatic cmp(input step_t s, input int idx, input logic [6:0] opc);
    logic [16:0] e, a;
    e = {s.adr, s.a, s.b, s.rs, s.op, s.rp ? mem_ready : s.pcw, s.rp ? mem_ready : 1'b0,
         s.memw, s.regw, s.rd ? mem_ready : s.done, 1'b0};
    a = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, PCWrite, IRWrite, MemWrite, RegWrite,
         instr_done, illegal};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle opcode=%h f3=%0d idx=%0d actual=%h required=%h", opc, funct3, idx, a, e);
    end
    if (idx < 16) begin
      op_at[idx] = ALUOp; b_at[idx] = ALUSrcB; rs_at[idx] = ResultSrc;
      pcw_at[idx] = PCWrite; regw_at[idx] = RegWrite; done_at[idx] = instr_done;
    end
    regw_n += int'(RegWrite); memw_n += int'(MemWrite); adr_n += int'(AdrSrc);
    done_n += int'(instr_done);
  endtask
  task automatic run(input logic [6:0] opc, input logic [2:0] f3, input logic f7, z, s, output int n);
    step_t cur;
    opcode = opc; funct3 = f3; funct7b5 = f7; Zero = z; Sign = s;
    build(opc, f3, f7, z, s);
    regw_n = 0; memw_n = 0; adr_n = 0; done_n = 0; n = 0;
    while (q.size() > 0) begin
      cur = q[0];
      mem_ready = (force_q.size() > 0) ? force_q.pop_front() : all_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      cmp(cur, n, opc);
      @(posedge clk);
      #1;
      n++;
      if (!(cur.wt && !mem_ready)) void'(q.pop_front());
      if (n > 64) begin
        checks++; errors++;
        $display("FAIL timeout opcode=%h actual=%0d cycles required<=64", opc, n);
        q.delete();
      end
    end
  endtask
  initial begin
    int n;
    logic [6:0] opc;
    logic [2:0] f3;
    opc_tab = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h00};
    mem_ready = 1;
    @(posedge clk);
    #1;
    chk("reset_enables", int'({PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal}), 0);
    chk("reset_selects", int'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp}), 'b0_00_10_10_0000);
    @(posedge clk);
    #1;
    rst_n = 1;
    all_rdy = 1;
    run(7'h33, 3'd0, 1'b0, 1'b0, 1'b0, n);
    chk("add_cycles", n, 4); chk("add_op", int'(op_at[2]), 0);
    chk("add_regw", int'({regw_at[3], done_at[3]}), 3); chk("add_regw_n", regw_n, 1);
    run(7'h33, 3'd0, 1'b1, 1'b0, 1'b0, n);
    chk("sub_op", int'(op_at[2]), 1);
    run(7'h13, 3'd5, 1'b1, 1'b0, 1'b0, n);
    chk("srai_op", int'(op_at[2]), 9); chk("srai_srcb", int'(b_at[2]), 1);
    run(7'h63, 3'd0, 1'b0, 1'b1, 1'b0, n);
    chk("beq_cycles", n, 3); chk("beq_taken", int'(pcw_at[2]), 1);
    run(7'h63, 3'd6, 1'b0, 1'b0, 1'b0, n);
    chk("bltu_op", int'(op_at[2]), 11); chk("bltu_pcw", int'(pcw_at[2]), 0);
    run(7'h67, 3'd0, 1'b0, 1'b0, 1'b0, n);
    chk("jalr_cycles", n, 5);
    force_q = '{1, 1, 1, 0, 0, 1, 1};
    run(7'h03, 3'd2, 1'b0, 1'b0, 1'b0, n);
    chk("lw_cycles", n, 7); chk("lw_regw_n", regw_n, 1);
    chk("lw_last", int'({regw_at[6], rs_at[6]}), 'b1_01);
    force_q = '{1, 1, 1, 0, 0, 0, 1};
    run(7'h23, 3'd2, 1'b0, 1'b0, 1'b0, n);
    chk("sw_cycles", n, 7); chk("sw_memw_n", memw_n, 4); chk("sw_adr_n", adr_n, 4);
    chk("sw_done", int'({done_n, done_at[6]}), 'b11);
    all_rdy = 0;
    for (int i = 0; i < 300; i++) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      opc = opc_tab[$urandom_range(0, 8)];
      f3 = 3'($urandom_range(0, 7));
      if (opc == 7'h63 && f3[2:1] == 2'b01) f3[2] = 1'b1;
`else
      opc = opc_tab[$urandom_range(0, 9)];
      if (opc == 7'h00) opc = ($urandom_range(0, 1) != 0) ? 7'h73 : 7'h00;
      f3 = 3'($urandom_range(0, 7));
`endif
      run(opc, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n);
    end
    all_rdy = 1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    opcode = 7'h00; mem_ready = 1;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 3; i++) begin
      chk("illegal_flag", int'(illegal), 1);
      chk("illegal_enables", int'({PCWrite, IRWrite, MemWrite, RegWrite, instr_done}), 0);
      @(posedge clk);
      #1;
    end
    rst_n = 0;
    #1;
    chk("illegal_cleared", int'(illegal), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
`else
    run(7'h00, 3'd0, 1'b0, 1'b0, 1'b0, n);
    chk("nop_cycles", n, 2); chk("nop_done", int'({done_at[1], illegal}), 'b10);
`endif
    opcode = 7'h23; funct3 = 3'd2; mem_ready = 1;
    repeat (2) begin @(posedge clk); #1; end
    mem_ready = 0;
    @(posedge clk);
    #1;
    chk("memwrite_high", int'({MemWrite, AdrSrc}), 3);
    #2;
    rst_n = 0;
    #1;
    chk("memwrite_drop", int'({MemWrite, instr_done, PCWrite, IRWrite, RegWrite}), 0);
    chk("memwrite_rst_sel", int'({AdrSrc, ALUSrcB, ResultSrc}), 'b0_10_10);
    @(posedge clk);
    #1;
    rst_n = 1;
    run(7'h37, 3'd0, 1'b0, 1'b0, 1'b0, n);
    chk("lui_after_reset", n, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle main controller: Moore state machine that sequences each RV32I instruction through fetch, decode, execute, memory and writeback. Drives datapath mux selects and write enables. Drives the ALU's 4-bit `Op` directly, using the ALU's own encoding. Resolves branches from the ALU's `Zero`/`Sign` flags. Sits directly upstream of the ALU in the multicycle datapath.

## Interface
- No parameters.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `opcode` in 7 — instr[6:0] from the instruction register.
- `funct3` in 3 — instr[14:12].
- `funct7b5` in 1 — instr[30].
- `mem_ready` in 1 — memory completes the current access this cycle.
- `Zero`, `Sign` in 1 each — ALU flags.
- `PCWrite`, `IRWrite`, `MemWrite`, `RegWrite` out 1 each — write enables.
- `AdrSrc` out 1 — memory address select: 0=PC, 1=ALUOut.
- `ALUSrcA` out 2 — 00=PC, 01=OldPC, 10=rs1, 11=zero.
- `ALUSrcB` out 2 — 00=rs2, 01=ImmExt, 10=constant 4.
- `ResultSrc` out 2 — 00=ALUOut, 01=memory data, 10=ALU result.
- `ALUOp` out 4 — ALU operation code.
- `instr_done` out 1 — one-cycle pulse in each instruction's final cycle.
- `illegal` out 1 — sticky illegal-instruction flag.

## Operation
- ALU codes: add 0, sub 1, and 2, or 3, xor 4, slt 5, sll 6, srl 8, sra 9, sltu 10, bltu 11 (result −1 if A<B unsigned).
- Defaults in every state: all enables 0, AdrSrc 0, ALUSrcA 00, ALUSrcB 00, ResultSrc 00, ALUOp add.
- FETCH: AdrSrc 0, SrcA 00, SrcB 10, ResultSrc 10, ALUOp add; IRWrite=PCWrite=mem_ready. Go to DECODE on mem_ready, else hold.
- DECODE: SrcA 01, SrcB 01, add, so ALUOut = OldPC+imm. Dispatch on opcode:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR; 0010011 → EXECI.
  - 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR.
  - 0110111 → LUI; 0010111 → AUIPC.
  - Any other opcode → see Configuration.
- MEMADR: SrcA 10, SrcB 01, add. Next: MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: AdrSrc 1. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc 01, RegWrite, instr_done → FETCH.
- MEMWRITE: AdrSrc 1, MemWrite held high until mem_ready; instr_done on the mem_ready cycle → FETCH.
- EXECR: SrcA 10, SrcB 00 → ALUWB. EXECI: SrcA 10, SrcB 01 → ALUWB.
- ALU op decode for EXECR/EXECI by funct3:
  - 000: sub when EXECR and funct7b5, otherwise add.
  - 001 sll; 010 slt; 011 sltu; 100 xor.
  - 101: sra when funct7b5, otherwise srl (R and I forms).
  - 110 or; 111 and.
- ALUWB: ResultSrc 00, RegWrite, instr_done → FETCH.
- BRANCH: SrcA 10, SrcB 00, ResultSrc 00, instr_done → FETCH. PCWrite = taken, combinational on the flags in this cycle:
  - beq(000): sub, taken if Zero. bne(001): sub, taken if !Zero.
  - blt(100): slt, taken if !Zero. bge(101): slt, taken if Zero.
  - bltu(110): op 11, taken if Sign. bgeu(111): op 11, taken if !Sign.
  - funct3 010/011 are illegal, detected in DECODE.
- JALR: SrcA 10, SrcB 01, add (ALUOut ← rs1+imm; bit 0 not cleared) → JAL.
- JAL: ResultSrc 00, PCWrite (PC ← ALUOut), SrcA 01, SrcB 10, add (ALUOut ← OldPC+4) → ALUWB.
- LUI: SrcA 11, SrcB 01, add → ALUWB. AUIPC: SrcA 01, SrcB 01, add → ALUWB.

## Timing
- Reset:
  - state=FETCH, illegal=0.
  - While rst_n is low, PCWrite, IRWrite, MemWrite, RegWrite and instr_done are forced 0; selects hold their FETCH values.
  - Reset asserted mid-instruction abandons it; no enable may glitch high.
- Cycles per instruction with mem_ready always 1:
  - lw 5; sw, R, I, LUI, AUIPC 4; branch 3; jal 4; jalr 5.
  - Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- All outputs except PCWrite (BRANCH, FETCH), IRWrite and MemWrite-completion are pure functions of state.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN`:
  - Defined: DECODE enters ILLEGAL on an unknown opcode or branch funct3 010/011. ILLEGAL sets `illegal`, drives all enables 0, and holds until reset.
  - Undefined: these encodings go straight to FETCH as a NOP with instr_done asserted, and `illegal` is tied 0.

## Test plan
- Reset release, mem_ready=1, add x3,x1,x2 (opcode 0110011, f3 000, f7b5 0) → states FETCH, DECODE, EXECR, ALUWB; ALUOp 0 in EXECR; RegWrite and instr_done in cycle 4.
- sub (f7b5=1) → ALUOp 1. srai (0010011, f3 101, f7b5 1) → ALUOp 9 with SrcB 01.
- beq with Zero=1 → PCWrite=1 in cycle 3. bltu with Sign=0 → ALUOp 11, PCWrite=0.
- lw with mem_ready low for 2 cycles in MEMREAD → 7 cycles total; RegWrite with ResultSrc 01 only in the final cycle.
- sw with mem_ready delayed 3 cycles → MemWrite high for 4 consecutive cycles, AdrSrc 1 throughout, instr_done on the last.
- Opcode 0000000: with the macro, `illegal`=1 and it stays set with no enables until rst_n pulses low; without the macro, FETCH follows on the next cycle. Also assert rst_n low during MEMWRITE → MemWrite drops immediately.
